// File: rtl/bus_mem_responder_if.sv
// Bus between memcontrol (master) and the memory responder (slave).
// The signal names follow the responder's view of the bus.
interface bus_mem_responder_if;
  logic [31:0] address_in;
  logic [31:0] data_in;
  logic        read;
  logic        write;
  logic [31:0] data_out;
  logic        bus_full;
  logic        ack;
  logic        err;
  logic [1:0]  state;

  modport master (
    output address_in, data_in, read, write,
    input  data_out, bus_full, ack, err, state
  );

  modport slave (
    input  address_in, data_in, read, write,
    output data_out, bus_full, ack, err, state
  );
endinterface

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the memcontrol data/instruction bus.
// Accepts one read or write at a time, holds bus_full while it is in
// flight, and completes after a fixed LATENCY with a one-cycle ack.
// Misaligned, out-of-range and read+write requests complete with err.
module bus_mem_responder #(
  parameter int          DEPTH    = 256,
  parameter int          LATENCY  = 2,
  parameter logic [31:0] BAD_DATA = 32'hBAD1BAD1
) (
  input logic       clk,
  input logic       rst,
  bus_mem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  // Wide enough to hold LATENCY-1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_RD  = 2'd0,
    OP_WR  = 2'd1,
    OP_ERR = 2'd2
  } op_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      dout_q;

  // Request stage: values captured at accept, stable for the whole access.
  logic [31:0]      addr_p0;
  logic [31:0]      wdata_p0;
  op_t              op_p0;

  logic [31:0]      mem [DEPTH];

  logic             accept;
  logic             complete;
  logic             addr_bad;
  logic             mem_we;
  logic             rd_done;
  logic [IDX_W-1:0] idx;
  op_t              op_in;

  assign idx      = addr_p0[IDX_W+1:2];
  assign addr_bad = (addr_p0[1:0] != 2'b00) || (addr_p0[31:IDX_W+2] != '0);
  assign op_in    = (bus.read && bus.write) ? OP_ERR :
                    (bus.read ? OP_RD : OP_WR);

  // Next-state, latency countdown and completion decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (bus.read || bus.write) begin
          accept  = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          complete = 1'b1;
          state_d  = DONE;
          err_d    = (op_p0 == OP_ERR) || addr_bad;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  // Storage is only touched by a good write; a reset in the same cycle aborts it.
  assign mem_we  = complete && (op_p0 == OP_WR) && !addr_bad && rst;
  assign rd_done = complete && (op_p0 == OP_RD);

  // Control state; a reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // ---- accept -> request stage ----
  // Capture the request; inputs seen while BUSY/DONE never reach here.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= bus.address_in;
      wdata_p0 <= bus.data_in;
      op_p0    <= op_in;
    end
  end

  // ---- request stage -> storage / read data ----
  // Storage array; deliberately has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= wdata_p0;
    end
  end

  // Read data holds between reads; errored reads return BAD_DATA.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q <= '0;
    end else if (rd_done) begin
      dout_q <= addr_bad ? BAD_DATA : mem[idx];
    end
  end

  assign bus.data_out = dout_q;
  assign bus.bus_full = (state_q != IDLE);
  assign bus.ack      = (state_q == DONE);
  assign bus.err      = err_q;
  assign bus.state    = state_q;

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Memory-side end of the data/instruction bus driven by memcontrol.
- Accepts a single read or write from memcontrol's address_out/data_out_BUS and returns read data on data_in_BUS.
- Holds bus_full high while a transaction is in flight. Backed by a word-addressed storage array with a programmable fixed access latency.
- Used as the system bus memory in simulation and in the FPGA top level.

Parameters:
DEPTH, 256, number of 32-bit words in the storage array (power of two, >= 2)
LATENCY, 2, cycles from accept to response (>= 1)
BAD_DATA, 32'hBAD1BAD1, read data returned on an errored access

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-low reset
address_in  input  32  byte address from memcontrol address_out
data_in  input  32  write data from memcontrol data_out_BUS
read  input  1  read request level
write  input  1  write request level
data_out  output  32  read data to memcontrol data_in_BUS
bus_full  output  1  responder busy; new requests not accepted
ack  output  1  one-cycle completion pulse
err  output  1  one-cycle error pulse, coincident with ack
state  output  2  FSM state for debug (IDLE=0, BUSY=1, DONE=2)

Behaviour:
- Reset (rst==0 at a rising edge):
  - state=IDLE, bus_full=0, ack=0, err=0, data_out=0, latency counter=0.
  - Storage contents are not cleared.
- Accept condition (IDLE):
  - A request is accepted at a rising edge when state==IDLE and (read^write)==1.
  - On accept, latch address_in, data_in and op; go to BUSY; bus_full=1; counter=LATENCY-1.
- Illegal request (IDLE, read&write both 1):
  - Not an access. Go to BUSY with op=ERR and the same latency and handshake as a normal request.
  - Completes with ack=1, err=1, no write, data_out unchanged.
- IDLE with read=write=0: remain in IDLE with bus_full=0.
- BUSY:
  - Counter decrements each edge.
  - At the edge where counter==0, perform the access and go to DONE with ack=1.
  - Write: mem[index] <= latched data.
  - Read: data_out <= mem[index].
  - BUSY therefore lasts exactly LATENCY cycles. ack is first visible LATENCY edges after the accept edge.
- DONE:
  - Lasts one cycle; bus_full stays 1.
  - Next edge: IDLE, bus_full=0, ack=0, err=0.
  - Earliest next accept is the edge after DONE→IDLE, so back-to-back transaction period = LATENCY+2 cycles.
- Request inputs while BUSY/DONE: ignored. Latched values are not modified. Requester holds request until bus_full falls; a still-asserted level in IDLE is a new request.
- Addressing:
  - index = address_in[log2(DEPTH)+1:2].
  - Misaligned (address_in[1:0]!=0) or out-of-range (address_in[31:log2(DEPTH)+2]!=0) sets err=1 with ack.
  - On such an error: no write; a read returns data_out=BAD_DATA.
- data_out holds its value between reads. It updates only on read completion (good or error).
- Mid-transaction reset: aborts immediately; no pending write is committed; outputs take reset values next cycle.
- A write followed by a read of the same index returns the new data (no forwarding needed; accesses are serialised).

Test Plan:
1. Reset: hold rst=0 two cycles with read=1 → state=0, bus_full=0, ack=0, data_out=0; release → accept on next edge, bus_full=1 one cycle later.
2. Write then read (LATENCY=2): write addr=0x10, data=0xDEADBEEF → ack on 2nd edge after accept, err=0. Then read addr=0x10 → data_out=0xDEADBEEF with ack, bus_full low one cycle after ack.
3. Busy lockout: during BUSY change address_in to 0x20 and assert write → ignored; the original transaction completes; mem[8] unchanged (a later read of 0x20 returns its prior value).
4. Errors: read addr=0x402 (misaligned) → ack=1, err=1, data_out=0xBAD1BAD1. Write addr=0x400 with DEPTH=256 → err=1, and a read of 0x0 shows no aliasing write.
5. Simultaneous read=write=1 in IDLE → ack=1, err=1 after LATENCY cycles; data_out and storage unchanged.
6. Reset mid-write: assert rst=0 one cycle after accepting write 0x4 ← 0x12345678 → state=IDLE, no ack; a subsequent read of 0x4 returns the old value.
